seq_comp_iter: RTL

- Iterative, clocked magnitude comparator. Consumes two WIDTH-bit operands two bits per cycle, MSB pair first.
- Carries an EQ/GT pair across cycles in a register, so the 2-bit cascade that is otherwise spatial becomes temporal.
- Sits beside the ALU as the low-area compare path for branch/slt evaluation, with a start/ready/done handshake.

---
 rtl/seq_comp_iter.sv | 79 +++++++
 1 files changed

// File: rtl/seq_comp_iter.sv
// seq_comp_iter: iterative magnitude comparator that walks two bits per cycle, MSB pair first.
// Ports: clock, reset (async, active-low), start/ready/done handshake, is_signed,
//        data_operandA/B (WIDTH), result flags isEqual/isGreaterThan/isLessThan (valid in DONE).
// Build option: define SEQ_COMP_EARLY_EXIT_EN to leave RUN as soon as the first differing pair is seen.
module seq_comp_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             ready,
  output logic             done,
  output logic             isEqual,
  output logic             isGreaterThan,
  output logic             isLessThan
);
  localparam int NP = WIDTH / 2;
  localparam int IW = $clog2(NP);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic             eq_q, eq_d, gt_q, gt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] flip;
  logic [1:0]       pa, pb;
  logic             accept, step, leave;
  // Flipping the sign bit of both operands maps two's complement onto offset binary,
  // so the unsigned pair cascade yields the signed ordering.
  assign flip   = {is_signed, {(WIDTH-1){1'b0}}};
  assign accept = start & ready;
  assign pa     = a_q[{idx_q, 1'b0} +: 2];
  assign pb     = b_q[{idx_q, 1'b0} +: 2];
  // Once a differing pair has been seen the verdict is final; later pairs are ignored.
  assign step   = (state_q == RUN) & eq_q;
`ifdef SEQ_COMP_EARLY_EXIT_EN
  assign leave  = (idx_q == '0) | (eq_q & (pa != pb));
`else
  assign leave  = (idx_q == '0);
`endif
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = accept ? RUN : ((state_q == RUN) && leave) ? DONE : state_q;
  end
  always_comb begin
    ready         = (state_q != RUN);
    done          = (state_q == DONE);
    isEqual       = done & eq_q;
    isGreaterThan = done & gt_q & ~eq_q;
    isLessThan    = done & ~gt_q & ~eq_q;
  end
  always_comb begin
    a_d   = accept ? (data_operandA ^ flip) : a_q;
    b_d   = accept ? (data_operandB ^ flip) : b_q;
    eq_d  = accept ? 1'b1 : step ? (pa == pb) : eq_q;
    gt_d  = accept ? 1'b0 : step ? (pa > pb) : gt_q;
    idx_d = accept ? IW'(NP - 1) : (state_q == RUN) ? idx_q - IW'(1) : idx_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      eq_q  <= 1'b1;
      gt_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      eq_q  <= eq_d;
      gt_q  <= gt_d;
      idx_q <= idx_d;
    end
  end
endmodule
